// File: rtl/lcd_panel_seq_pkg.sv
// Shared types and strap decode for the LCD panel bring-up path.
// Latency: n/a (package). Backpressure: n/a.
// Holds the sequencer state enum, registered-output bundle, strap codes,
// panel IDs and the code->{valid,id} decode used by clock/timing blocks.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_PANEL,
    ST_RELEASE,
    ST_SAMPLE,
    ST_DECODE,
    ST_CLK_ON,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Strap codes {M2,M1,M0} and the panel IDs they select.
  localparam logic [2:0]  CODE_4342 = 3'b000;
  localparam logic [2:0]  CODE_7084 = 3'b001;
  localparam logic [2:0]  CODE_7016 = 3'b010;
  localparam logic [2:0]  CODE_4384 = 3'b100;
  localparam logic [2:0]  CODE_1018 = 3'b101;
  localparam logic [15:0] ID_4342   = 16'h4342;
  localparam logic [15:0] ID_7084   = 16'h7084;
  localparam logic [15:0] ID_7016   = 16'h7016;
  localparam logic [15:0] ID_4384   = 16'h4384;
  localparam logic [15:0] ID_1018   = 16'h1018;

  typedef struct packed {
    logic        valid;
    logic [15:0] id;
  } id_dec_t;

  // All sequencer outputs, kept together so they are registered as one.
  typedef struct packed {
    logic        id_oe;
    logic        lcd_rst_n;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        pclk_en;
    logic        lcd_bl;
    logic        busy;
    logic        err;
  } out_t;

  localparam out_t OUT_RESET = '{id_oe: 1'b0, lcd_rst_n: 1'b0, lcd_id: 16'h0000,
                                 id_valid: 1'b0, pclk_en: 1'b0, lcd_bl: 1'b0,
                                 busy: 1'b1, err: 1'b0};
  localparam out_t OUT_ERROR = '{id_oe: 1'b0, lcd_rst_n: 1'b1, lcd_id: 16'h0000,
                                 id_valid: 1'b0, pclk_en: 1'b0, lcd_bl: 1'b0,
                                 busy: 1'b0, err: 1'b1};

  function automatic id_dec_t decode_id(input logic [2:0] code);
    id_dec_t r;
    r.valid = 1'b1;
    case (code)
      CODE_4342: r.id = ID_4342;
      CODE_7084: r.id = ID_7084;
      CODE_7016: r.id = ID_7016;
      CODE_4384: r.id = ID_4384;
      CODE_1018: r.id = ID_1018;
      default: begin
        r.valid = 1'b0;
        r.id    = 16'h0000;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_panel_seq_if.sv
// Control/status bundle between the panel sequencer and its surroundings.
// Latency: n/a (wiring only). Backpressure: none; all signals are levels/pulses.
// master = sequencer (drives panel/status outputs), slave = surrounding logic.
interface lcd_panel_seq_if;
  logic        restart;   // 1-cycle pulse: re-run the whole sequence
  logic [2:0]  id_pins;   // raw {M2,M1,M0} straps, asynchronous
  logic        id_oe;     // 1 = FPGA drives RGB bus, 0 = bus released
  logic        lcd_rst_n; // panel reset, active low
  logic [15:0] lcd_id;    // decoded panel ID, 0 until valid
  logic        id_valid;  // lcd_id valid and stable
  logic        pclk_en;   // pixel clock divider / timing generator enable
  logic        lcd_bl;    // backlight enable
  logic        busy;      // sequence in progress
  logic        err;       // identification failed

  modport master (
    input  restart, id_pins,
    output id_oe, lcd_rst_n, lcd_id, id_valid, pclk_en, lcd_bl, busy, err
  );

  modport slave (
    output restart, id_pins,
    input  id_oe, lcd_rst_n, lcd_id, id_valid, pclk_en, lcd_bl, busy, err
  );
endinterface

// File: rtl/lcd_panel_seq_sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs (panel straps).
// Latency: 2 clk cycles. Backpressure: none.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcd_panel_seq.sv
// Panel power-up sequencer: reset pulse, strap read/debounce/decode, pclk then backlight enable.
// Latency: RST + SETTLE + STABLE (+1 decode) cycles to id_valid; pclk_en 1 later; lcd_bl BL_DELAY later.
// Backpressure: none; restart (any state) and rst_n re-run the sequence. Ports: clk, rst_n, bus (master).
module lcd_panel_seq
  import lcd_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = 50000,
  parameter int unsigned SETTLE_CYCLES   = 50000,
  parameter int unsigned STABLE_SAMPLES  = 16,
  parameter int unsigned SAMPLE_TIMEOUT  = 4096,
  parameter int unsigned BL_DELAY_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  lcd_panel_seq_if.master bus
);

  localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_B   = (SAMPLE_TIMEOUT > BL_DELAY_CYCLES) ? SAMPLE_TIMEOUT : BL_DELAY_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned STB_W   = $clog2(STABLE_SAMPLES + 1);

  // Reload values: a state loaded with N-1 leaves on the cycle the count hits 0,
  // so it occupies exactly N cycles.
  localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(SAMPLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_BL      = CNT_W'(BL_DELAY_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_TGT    = STB_W'(STABLE_SAMPLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STB_W-1:0] stb_q, stb_d, stb_nx;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       code_sync;
  out_t             out_q, out_d;
  id_dec_t          dec_now, dec_lat;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.id_pins),
    .q     (code_sync)
  );

  assign dec_now = decode_id(code_sync);
  assign dec_lat = decode_id(code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST_PANEL;
      cnt_q   <= LD_RST;
      stb_q   <= '0;
      prev_q  <= '0;
      code_q  <= '0;
      out_q   <= OUT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      prev_q  <= prev_d;
      code_q  <= code_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;  // saturate at zero
    stb_d   = stb_q;
    stb_nx  = stb_q;
    prev_d  = prev_q;
    code_d  = code_q;
    out_d   = out_q;

    case (state_q)
      ST_RST_PANEL: if (cnt_q == '0) begin
        state_d         = ST_RELEASE;
        cnt_d           = LD_SETTLE;
        out_d.lcd_rst_n = 1'b1;
      end
      ST_RELEASE: if (cnt_q == '0) begin
        state_d = ST_SAMPLE;
        cnt_d   = LD_TIMEOUT;
        stb_d   = '0;
      end
      ST_SAMPLE: begin
        // stb_q==0 marks the first sample, which has nothing to compare against.
        stb_nx = (stb_q != '0 && code_sync == prev_q) ? stb_q + 1'b1 : STB_W'(1);
        stb_d  = stb_nx;
        prev_d = code_sync;
        if (stb_nx == STB_TGT) begin
          // ID is published on the way into DECODE so pclk_en, raised on
          // leaving DECODE, trails id_valid by exactly one cycle.
          state_d        = ST_DECODE;
          cnt_d          = '0;
          code_d         = code_sync;
          out_d.lcd_id   = dec_now.id;
          out_d.id_valid = dec_now.valid;
        end else if (cnt_q == '0) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
          out_d   = OUT_ERROR;
        end
      end
      ST_DECODE: begin
        if (dec_lat.valid) begin
          state_d       = ST_CLK_ON;
          cnt_d         = LD_BL;
          out_d.pclk_en = 1'b1;
          out_d.id_oe   = 1'b1;
        end else begin
          state_d = ST_ERROR;
          cnt_d   = '0;
          out_d   = OUT_ERROR;
        end
      end
      ST_CLK_ON: if (cnt_q == '0) begin
        state_d      = ST_RUN;
        cnt_d        = '0;
        out_d.lcd_bl = 1'b1;
        out_d.busy   = 1'b0;
      end
      default: ;  // ST_RUN / ST_ERROR hold until restart
    endcase

    if (bus.restart) begin
      state_d = ST_RST_PANEL;
      cnt_d   = LD_RST;
      stb_d   = '0;
      out_d   = OUT_RESET;
    end
  end

  assign bus.id_oe     = out_q.id_oe;
  assign bus.lcd_rst_n = out_q.lcd_rst_n;
  assign bus.lcd_id    = out_q.lcd_id;
  assign bus.id_valid  = out_q.id_valid;
  assign bus.pclk_en   = out_q.pclk_en;
  assign bus.lcd_bl    = out_q.lcd_bl;
  assign bus.busy      = out_q.busy;
  assign bus.err       = out_q.err;

endmodule
